ex_div: RTL and testbench
=========================

# ex_div

Iterative RV32M divide/remainder unit in the execute stage, fed directly by the ID/EX pipeline register outputs. It computes DIV, DIVU, REM and REMU using a restoring shift-subtract loop, one quotient bit per cycle. While it works it holds the front of the pipeline through a stall request, which feeds the ID/EX register's stall input. Divide-by-zero and signed overflow are resolved without iterating.

## Interface
- `XLEN`, default 32: operand/result width.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start_i`  in  1  EX holds a valid, unflushed M-extension divide (opcode 0110011, funct7 0000001, funct3[2]=1).
- `op_i`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `rs1_i`  in  XLEN  dividend (ID/EX rs1 data).
- `rs2_i`  in  XLEN  divisor (ID/EX rs2 data).
- `flush_i`  in  1  kill the in-flight divide.
- `stall_o`  out  1  hold IF/ID and ID/EX; connect to their stall inputs.
- `done_o`  out  1  `result_o` valid this cycle (one-cycle pulse).
- `result_o`  out  XLEN  quotient or remainder.

## Operation
- States:
  - IDLE, CALC, FIX, DONE.
  - Registered: dividend/quotient shift register (XLEN), partial remainder (XLEN+1), divisor magnitude (XLEN), bit counter (clog2(XLEN)+1), captured op, sign flags.
- Reset or `flush_i`:
  - Next state IDLE, counter 0, `done_o`=0, `result_o`=0, all datapath registers 0.
  - `flush_i` takes priority over `start_i` and over any state transition.
- IDLE, `start_i`=1:
  - Capture `op_i`.
  - Signed ops (DIV, REM): take absolute values of both operands; record `qneg` = rs1[MSB]^rs2[MSB] and `rneg` = rs1[MSB].
  - Unsigned ops: `qneg` = `rneg` = 0.
  - Divisor == 0: go to DONE with result = all-ones for DIV/DIVU, rs1 for REM/REMU.
  - Signed op with rs1 = 0x8000_0000 (MSB-only) and rs2 = all-ones: go to DONE with result = rs1 for DIV, 0 for REM.
  - Otherwise: go to CALC, counter = XLEN.
- CALC, once per cycle:
  - rem' = {rem[XLEN-1:0], dq[MSB]}, dq <<= 1.
  - If rem' >= divisor: rem' -= divisor, dq[0]=1.
  - Decrement counter; when the counter reaches 1, go to FIX.
- FIX:
  - Select quotient (dq) or remainder (rem[XLEN-1:0]) by op.
  - Two's-complement negate if `qneg` (quotient) or `rneg` (remainder).
  - Register into `result_o`; go to DONE.
- DONE:
  - `done_o`=1, `result_o` held; go to IDLE unconditionally.
  - `start_i` is ignored here: it still reflects the instruction just completed.
- `result_o` holds its last value until it is next written; only `done_o` qualifies it.

## Timing
- `stall_o` = (state==CALC) | (state==FIX) | (state==IDLE & `start_i` & ~`flush_i`). It is combinational and never asserted in DONE.
- Normal path, with `start_i` seen in IDLE at cycle T:
  - CALC for cycles T+1..T+XLEN.
  - FIX at T+XLEN+1.
  - DONE at T+XLEN+2.
  - `stall_o` is high for XLEN+2 cycles (T..T+XLEN+1).
  - For XLEN=32: `done_o` at T+34.
- Special-case path: DONE at T+1, `stall_o` high only in cycle T.
- ID/EX inputs are stable while `stall_o` is high. Operands are sampled only at T; later changes are ignored.
- Back-to-back divides:
  - ID/EX advances on the DONE cycle, so the next `start_i` is seen in IDLE at DONE+1.
  - The minimum issue interval is XLEN+3 cycles.
- `flush_i` in any state: state is IDLE from the next cycle. No `done_o` pulse follows for the killed operation. A `start_i` presented in the cycle after the flush is accepted normally.
- Reset asserted mid-CALC: identical to the flush behaviour, plus `result_o` is cleared to 0.

## Test plan
- DIVU rs1=100, rs2=7, `start_i` at T:
  - `stall_o` high T..T+33.
  - `done_o`=1 and `result_o`=14 at T+34.
  - Repeat with REMU: `result_o`=2.
- DIV rs1=-7 (0xFFFF_FFF9), rs2=2: `result_o`=0xFFFF_FFFD. REM with the same operands: `result_o`=0xFFFF_FFFF.
- Divide by zero, rs1=5, rs2=0:
  - DIV gives 0xFFFF_FFFF at T+1; REMU gives 5 at T+1.
  - `stall_o` high only at T.
- Signed overflow, rs1=0x8000_0000, rs2=0xFFFF_FFFF:
  - DIV gives 0x8000_0000 at T+1; REM gives 0 at T+1.
  - DIVU with the same operands iterates and gives 0 at T+34.
- `flush_i` pulsed at T+10 during a DIVU:
  - IDLE at T+11, `stall_o`=0, no `done_o` afterwards.
  - A new DIVU 9/3 with `start_i` at T+11 gives `done_o` and `result_o`=3 at T+45.
- Reset and back-to-back:
  - `rst_n` low at T+5 of a divide: all outputs 0 at T+6.
  - After release, two consecutive DIVUs (100/7, then 50/5) give `done_o` at T0+34 and T0+69 with results 14 and 10.

Source files
------------

// File: rtl/ex_div.sv
// Iterative RV32M divide/remainder unit for the execute stage.
// Restoring shift-subtract, one quotient bit per cycle, stalls the front end while busy.
module ex_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    // state | meaning
    // IDLE  | waiting for a divide in EX
    // CALC  | one restoring step per cycle
    // FIX   | pick quotient/remainder, apply sign
    // DONE  | result_o valid, done_o pulse
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ONE     = XLEN'(1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    logic [XLEN-1:0] dq;
    logic [XLEN:0]   rem;
    logic [XLEN-1:0] dvs;
    logic [CW-1:0]   cnt;
    logic [1:0]      op;
    logic            qneg;
    logic            rneg;

    logic            signed_op;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            ovf;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            ge;
    logic [XLEN-1:0] sel;
    logic            neg;
    logic [XLEN-1:0] fix_res;

    always_comb begin
        signed_op = ~op_i[0];
        a_abs     = (signed_op && rs1_i[XLEN-1]) ? (~rs1_i + ONE) : rs1_i;
        b_abs     = (signed_op && rs2_i[XLEN-1]) ? (~rs2_i + ONE) : rs2_i;
        div_zero  = (rs2_i == '0);
        ovf       = signed_op && (rs1_i == MIN_NEG) && (rs2_i == '1);
        // rem[XLEN] is zero after every step; OR-ing it in keeps the compare exact
        rem_sh    = {rem[XLEN-1:0], dq[XLEN-1]};
        rem_sub   = rem_sh - {1'b0, dvs};
        ge        = (rem_sh >= {1'b0, dvs}) | rem[XLEN];
        sel       = op[1] ? rem[XLEN-1:0] : dq;
        neg       = op[1] ? rneg : qneg;
        fix_res   = neg ? (~sel + ONE) : sel;
    end

    assign stall_o = (state == CALC) || (state == FIX) ||
                     ((state == IDLE) && start_i && !flush_i);

    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            state    <= IDLE;
            dq       <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            op       <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        op <= op_i;
                        if (div_zero) begin
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= op_i[1] ? rs1_i : '1;
                        end else if (ovf) begin
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= op_i[1] ? '0 : rs1_i;
                        end else begin
                            state <= CALC;
                            dq    <= a_abs;
                            dvs   <= b_abs;
                            rem   <= '0;
                            cnt   <= CW'(XLEN);
                            qneg  <= signed_op & (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]);
                            rneg  <= signed_op & rs1_i[XLEN-1];
                        end
                    end
                end
                CALC: begin
                    rem <= ge ? rem_sub : rem_sh;
                    dq  <= {dq[XLEN-2:0], ge};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_o <= fix_res;
                    done_o   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    // start_i still shows the finished instruction here
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, stall window, signs,
// divide-by-zero, overflow, flush, reset and back-to-back issue.
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int total = 0;
    int bad = 0;

    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    ex_div #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_i     (op_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a divide in the current cycle T and checks every cycle up to done.
    task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input int lat);
        op_i    = op;
        rs1_i   = a;
        rs2_i   = b;
        start_i = 1'b1;
        #1;
        chk({tag, "_stall_T"}, {31'b0, stall_o}, 32'd1);
        chk({tag, "_done_T"}, {31'b0, done_o}, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            step();
            if (k == 3) begin
                rs1_i = ~a;
                rs2_i = b + 32'd1;
            end
            @(negedge clk);
            if (k < lat) begin
                chk({tag, "_stall_busy"}, {31'b0, stall_o}, 32'd1);
                chk({tag, "_done_busy"}, {31'b0, done_o}, 32'd0);
            end else begin
                chk({tag, "_stall_done"}, {31'b0, stall_o}, 32'd0);
                chk({tag, "_done"}, {31'b0, done_o}, 32'd1);
                chk({tag, "_result"}, result_o, exp);
            end
        end
    endtask

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_result", result_o, 32'd0);
        rst_n = 1'b1;
        step();

        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        step(); start_i = 1'b0;
        chk("post_done_low", {31'b0, done_o}, 32'd0);
        chk("result_held", result_o, 32'd14);
        run_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
        step(); start_i = 1'b0;
        run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        step(); start_i = 1'b0;
        run_div("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        step(); start_i = 1'b0;
        run_div("div_20_m3", OP_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
        step(); start_i = 1'b0;
        run_div("rem_20_m3", OP_REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 34);
        step(); start_i = 1'b0;
        run_div("div_by0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        step(); start_i = 1'b0;
        run_div("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
        step(); start_i = 1'b0;
        run_div("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        step(); start_i = 1'b0;
        run_div("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        step(); start_i = 1'b0;
        run_div("divu_ovf_ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        step(); start_i = 1'b0;
        run_div("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, 34);
        step(); start_i = 1'b0;

        // flush at T+10 kills the divide; new one starts at T+11
        op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd7; start_i = 1'b1;
        repeat (10) step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk("flush_stall", {31'b0, stall_o}, 32'd0);
        chk("flush_done", {31'b0, done_o}, 32'd0);
        run_div("after_flush_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 34);
        step(); start_i = 1'b0;

        // reset at T+5 of a divide
        op_i = OP_DIVU; rs1_i = 32'd100; rs2_i = 32'd7; start_i = 1'b1;
        repeat (5) step();
        rst_n = 1'b0;
        start_i = 1'b0;
        step();
        @(negedge clk);
        chk("midrst_stall", {31'b0, stall_o}, 32'd0);
        chk("midrst_done", {31'b0, done_o}, 32'd0);
        chk("midrst_result", result_o, 32'd0);
        rst_n = 1'b1;
        step();

        run_div("b2b_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        step();
        run_div("b2b_50_5", OP_DIVU, 32'd50, 32'd5, 32'd10, 34);
        step(); start_i = 1'b0;
        repeat (3) step();
        chk("final_done", {31'b0, done_o}, 32'd0);
        chk("final_result", result_o, 32'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
